// File: rtl/intr_prio_sched.sv
// -----------------------------------------------------------------------------
// intr_prio_sched
//   Priority-scheduling interrupt controller for a bank of PERIPHERALS sources.
//   Level requests on intr_active are latched into a sticky pending register.
//   The highest-priority pending source with a non-zero priority is presented
//   on intr_valid / intr_to_serv and held there (no preemption) until the
//   processor pulses intr_service. Per-source priorities live behind a simple
//   request/ready register port.
//
// Ports
//   clk           clock, all logic on posedge
//   rst           synchronous active-low reset
//   wr_rd         1 = write, 0 = read (register port)
//   enable        register access request
//   addr          source index whose priority register is accessed
//   wdata         priority value to write
//   rdata         read data, holds until the next read completes
//   ready         one-cycle access-complete pulse
//   error         access rejected, valid together with ready
//   intr_active   level interrupt requests, one bit per source
//   intr_service  processor completion pulse for the presented interrupt
//   intr_valid    an interrupt is being presented
//   intr_to_serv  index of the presented interrupt
//   dbg_state     scheduler FSM state (0 = IDLE, 1 = SERVE)
//
// Register port handshake: an access is accepted on a posedge where
// enable = 1 and ready = 0; ready is high for exactly the following cycle and
// error is meaningful only while ready = 1. enable is ignored while ready = 1,
// so the port completes at most one access every two cycles.
// -----------------------------------------------------------------------------
module intr_prio_sched #(
  parameter int PERIPHERALS = 16,
  parameter int IDX_W       = $clog2(PERIPHERALS),
  parameter int PRIO_W      = $clog2(PERIPHERALS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_rd,
  input  logic                   enable,
  input  logic [IDX_W-1:0]       addr,
  input  logic [PRIO_W-1:0]      wdata,
  output logic [PRIO_W-1:0]      rdata,
  output logic                   ready,
  output logic                   error,
  input  logic [PERIPHERALS-1:0] intr_active,
  input  logic                   intr_service,
  output logic                   intr_valid,
  output logic [IDX_W-1:0]       intr_to_serv,
  output logic [0:0]             dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [PRIO_W-1:0]      r_prio [PERIPHERALS];
  logic [PERIPHERALS-1:0] r_pend;
  logic [0:0]             r_state;
  logic                   r_valid;
  logic [IDX_W-1:0]       r_to_serv;
  logic [PRIO_W-1:0]      r_rdata;
  logic                   r_ready;
  logic                   r_error;

  logic                   w_accept;
  logic                   w_reject;
  logic                   w_done;
  logic [PERIPHERALS-1:0] w_clr;
  logic [PRIO_W-1:0]      w_best;
  logic [IDX_W-1:0]       w_win;
  logic                   w_any;

  assign w_accept = enable && !r_ready;
  // A write aimed at the interrupt currently being presented is dropped so
  // the processor never sees its priority change underneath it.
  assign w_reject = wr_rd && r_valid && (addr == r_to_serv);

  // Service completion only counts while actually serving.
  assign w_done = (r_state == ST_SERVE) && intr_service;
  assign w_clr  = w_done ? ({{(PERIPHERALS-1){1'b0}}, 1'b1} << r_to_serv)
                         : '0;

  // Winner search: strict '>' starting from 0 keeps masked (prio 0) sources
  // out and resolves ties toward the lowest index.
  always_comb begin
    w_best = '0;
    w_win  = '0;
    for (int i = 0; i < PERIPHERALS; i++) begin
      if (r_pend[i] && (r_prio[i] > w_best)) begin
        w_best = r_prio[i];
        w_win  = IDX_W'(i);
      end
    end
  end
  assign w_any = (w_best != '0);

  // Register port
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PERIPHERALS; i++) r_prio[i] <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ready <= w_accept;
      r_error <= 1'b0;
      if (w_accept) begin
        if (wr_rd) begin
          if (w_reject) r_error <= 1'b1;
          else          r_prio[addr] <= wdata;
        end else begin
          r_rdata <= r_prio[addr];
        end
      end
    end
  end

  // Pending register: set wins over the completion clear.
  always_ff @(posedge clk) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= (r_pend & ~w_clr) | intr_active;
  end

  // Scheduler FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_to_serv <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_to_serv <= w_win;
            r_valid   <= 1'b1;
            r_state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (intr_service) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata        = r_rdata;
  assign ready        = r_ready;
  assign error        = r_error;
  assign intr_valid   = r_valid;
  assign intr_to_serv = r_to_serv;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_intr_prio_sched.sv
// -----------------------------------------------------------------------------
// tb_intr_prio_sched
//   Directed testbench for intr_prio_sched. Inputs are driven 1 time unit
//   after each posedge and outputs are sampled at the same point, so every
//   sample reflects the state registered on the preceding edge.
// -----------------------------------------------------------------------------
module tb_intr_prio_sched;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int PW = 4;

  logic          clk;
  logic          rst;
  logic          wr_rd;
  logic          enable;
  logic [IW-1:0] addr;
  logic [PW-1:0] wdata;
  logic [PW-1:0] rdata;
  logic          ready;
  logic          error;
  logic [N-1:0]  intr_active;
  logic          intr_service;
  logic          intr_valid;
  logic [IW-1:0] intr_to_serv;
  logic [0:0]    dbg_state;

  int checks;
  int failures;

  intr_prio_sched dut (
    .clk          (clk),
    .rst          (rst),
    .wr_rd        (wr_rd),
    .enable       (enable),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .error        (error),
    .intr_active  (intr_active),
    .intr_service (intr_service),
    .intr_valid   (intr_valid),
    .intr_to_serv (intr_to_serv),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    wr_rd        = 1'b0;
    enable       = 1'b0;
    addr         = '0;
    wdata        = '0;
    intr_active  = '0;
    intr_service = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // One register access: returns ready/rdata/error in the completion cycle and
  // ready one cycle later.
  task automatic reg_access(input logic wr, input logic [IW-1:0] a,
                            input logic [PW-1:0] d,
                            output logic rdy, output logic [PW-1:0] rd,
                            output logic er, output logic rdy_after);
    enable = 1'b1;
    wr_rd  = wr;
    addr   = a;
    wdata  = d;
    step();
    enable    = 1'b0;
    rdy       = ready;
    rd        = rdata;
    er        = error;
    step();
    rdy_after = ready;
  endtask

  task automatic write_prio(input logic [IW-1:0] a, input logic [PW-1:0] d);
    logic r, e, r2;
    logic [PW-1:0] rd;
    reg_access(1'b1, a, d, r, rd, e, r2);
  endtask

  task automatic pulse_active(input logic [N-1:0] v);
    intr_active = v;
    step();
    intr_active = '0;
  endtask

  task automatic pulse_service();
    intr_service = 1'b1;
    step();
    intr_service = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output logic ok);
    ok = intr_valid;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      step();
      ok = intr_valid;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic r, e, r2;
    logic [PW-1:0] rd;
    do_reset();
    checks++;
    if ({intr_valid, intr_to_serv, ready, error, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b idx=%0d ready=%0b err=%0b rdata=%0d, want all 0",
               intr_valid, intr_to_serv, ready, error, rdata);
    end
    checks++;
    if (dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    reg_access(1'b0, 4'd5, 4'd0, r, rd, e, r2);
    checks++;
    if ({r, e, rd} !== {1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL reset_read5: ready=%0b err=%0b rdata=%0d, want 1 0 0", r, e, rd);
    end
    checks++;
    if (r2 !== 1'b0) begin
      failures++;
      $display("FAIL ready_one_cycle: ready after=%0b want 0", r2);
    end
    pulse_active(16'h0020);
    repeat (4) step();
    checks++;
    if (intr_valid !== 1'b0) begin
      failures++;
      $display("FAIL masked_no_grant: valid=%0b want 0", intr_valid);
    end
    // Still pending while masked; enabling it must produce a grant.
    write_prio(4'd5, 4'd3);
    checks++;
    if ({intr_valid, intr_to_serv} !== {1'b1, 4'd5}) begin
      failures++;
      $display("FAIL unmask_grant: valid=%0b idx=%0d want 1 5", intr_valid, intr_to_serv);
    end
    pulse_service();
  endtask

  task automatic test_basic_grant();
    do_reset();
    write_prio(4'd5, 4'd3);
    intr_active = 16'h0020;
    step();
    intr_active = '0;
    checks++;
    if ({intr_valid, dut.r_pend[5]} !== 2'b01) begin
      failures++;
      $display("FAIL latency_pend: valid=%0b pend5=%0b want 0 1", intr_valid, dut.r_pend[5]);
    end
    step();
    checks++;
    if ({intr_valid, intr_to_serv} !== {1'b1, 4'd5}) begin
      failures++;
      $display("FAIL basic_grant: valid=%0b idx=%0d want 1 5", intr_valid, intr_to_serv);
    end
    repeat (10) step();
    checks++;
    if ({intr_valid, intr_to_serv, dbg_state} !== {1'b1, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL basic_hold: valid=%0b idx=%0d st=%0d want 1 5 1",
               intr_valid, intr_to_serv, dbg_state);
    end
    pulse_service();
    checks++;
    if ({intr_valid, dut.r_pend[5], dbg_state} !== 3'b000) begin
      failures++;
      $display("FAIL basic_service: valid=%0b pend5=%0b st=%0d want 0 0 0",
               intr_valid, dut.r_pend[5], dbg_state);
    end
    // Service pulse in IDLE has no effect.
    pulse_service();
    checks++;
    if ({intr_valid, dbg_state} !== 2'b00) begin
      failures++;
      $display("FAIL idle_service: valid=%0b st=%0d want 0 0", intr_valid, dbg_state);
    end
  endtask

  task automatic test_priority_tie();
    logic ok;
    logic [IW-1:0] exp_idx [3];
    exp_idx[0] = 4'd2;
    exp_idx[1] = 4'd9;
    exp_idx[2] = 4'd12;
    do_reset();
    write_prio(4'd2, 4'd7);
    write_prio(4'd9, 4'd7);
    write_prio(4'd12, 4'd4);
    pulse_active(16'h1204);
    for (int k = 0; k < 3; k++) begin
      wait_valid(8, ok);
      checks++;
      if (!ok || intr_to_serv !== exp_idx[k]) begin
        failures++;
        $display("FAIL tie_order[%0d]: valid=%0b idx=%0d want 1 %0d",
                 k, ok, intr_to_serv, exp_idx[k]);
      end
      pulse_service();
      checks++;
      if (intr_valid !== 1'b0) begin
        failures++;
        $display("FAIL tie_gap[%0d]: valid=%0b want 0", k, intr_valid);
      end
    end
    do_reset();
    write_prio(4'd2, 4'd7);
    write_prio(4'd9, 4'd7);
    write_prio(4'd12, 4'd9);
    pulse_active(16'h1204);
    wait_valid(8, ok);
    checks++;
    if (!ok || intr_to_serv !== 4'd12) begin
      failures++;
      $display("FAIL prio_high_first: valid=%0b idx=%0d want 1 12", ok, intr_to_serv);
    end
  endtask

  task automatic test_no_preempt();
    logic ok;
    do_reset();
    write_prio(4'd3, 4'd2);
    write_prio(4'd8, 4'd15);
    pulse_active(16'h0008);
    wait_valid(8, ok);
    checks++;
    if (!ok || intr_to_serv !== 4'd3) begin
      failures++;
      $display("FAIL preempt_first: valid=%0b idx=%0d want 1 3", ok, intr_to_serv);
    end
    pulse_active(16'h0100);
    repeat (5) step();
    checks++;
    if ({intr_valid, intr_to_serv} !== {1'b1, 4'd3}) begin
      failures++;
      $display("FAIL no_preempt: valid=%0b idx=%0d want 1 3", intr_valid, intr_to_serv);
    end
    pulse_service();
    checks++;
    if (intr_valid !== 1'b0) begin
      failures++;
      $display("FAIL preempt_gap: valid=%0b want 0", intr_valid);
    end
    step();
    checks++;
    if ({intr_valid, intr_to_serv} !== {1'b1, 4'd8}) begin
      failures++;
      $display("FAIL sticky_grant: valid=%0b idx=%0d want 1 8", intr_valid, intr_to_serv);
    end
  endtask

  task automatic test_write_reject();
    logic ok, r, e, r2;
    logic [PW-1:0] rd;
    do_reset();
    write_prio(4'd4, 4'd5);
    pulse_active(16'h0010);
    wait_valid(8, ok);
    checks++;
    if (!ok || intr_to_serv !== 4'd4) begin
      failures++;
      $display("FAIL reject_setup: valid=%0b idx=%0d want 1 4", ok, intr_to_serv);
    end
    reg_access(1'b1, 4'd4, 4'd1, r, rd, e, r2);
    checks++;
    if ({r, e} !== 2'b11) begin
      failures++;
      $display("FAIL reject_error: ready=%0b err=%0b want 1 1", r, e);
    end
    reg_access(1'b0, 4'd4, 4'd0, r, rd, e, r2);
    checks++;
    if ({e, rd} !== {1'b0, 4'd5}) begin
      failures++;
      $display("FAIL reject_unchanged: err=%0b prio4=%0d want 0 5", e, rd);
    end
    reg_access(1'b1, 4'd6, 4'd9, r, rd, e, r2);
    checks++;
    if ({r, e} !== 2'b10) begin
      failures++;
      $display("FAIL other_write: ready=%0b err=%0b want 1 0", r, e);
    end
    reg_access(1'b0, 4'd6, 4'd0, r, rd, e, r2);
    checks++;
    if (rd !== 4'd9) begin
      failures++;
      $display("FAIL other_updated: prio6=%0d want 9", rd);
    end
  endtask

  task automatic test_set_wins_and_reset();
    logic ok, r, e, r2;
    logic [PW-1:0] rd;
    do_reset();
    write_prio(4'd1, 4'd6);
    intr_active = 16'h0002;
    wait_valid(8, ok);
    checks++;
    if (!ok || intr_to_serv !== 4'd1) begin
      failures++;
      $display("FAIL setwins_first: valid=%0b idx=%0d want 1 1", ok, intr_to_serv);
    end
    pulse_service();
    checks++;
    if ({intr_valid, dut.r_pend[1]} !== 2'b01) begin
      failures++;
      $display("FAIL setwins_repend: valid=%0b pend1=%0b want 0 1", intr_valid, dut.r_pend[1]);
    end
    intr_active = 16'h0080;
    step();
    intr_active = '0;
    checks++;
    if ({intr_valid, intr_to_serv} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL setwins_regrant: valid=%0b idx=%0d want 1 1", intr_valid, intr_to_serv);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({intr_valid, intr_to_serv, dbg_state, dut.r_pend} !== '0) begin
      failures++;
      $display("FAIL midop_reset: valid=%0b idx=%0d st=%0d pend=%04h want 0 0 0 0000",
               intr_valid, intr_to_serv, dbg_state, dut.r_pend);
    end
    rst = 1'b1;
    reg_access(1'b0, 4'd1, 4'd0, r, rd, e, r2);
    checks++;
    if (rd !== 4'd0) begin
      failures++;
      $display("FAIL midop_prio_cleared: prio1=%0d want 0", rd);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_grant();
    test_priority_tie();
    test_no_preempt();
    test_write_reject();
    test_set_wins_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/intr_prio_sched.md
Name: intr_prio_sched

Overview:
- Priority-scheduling interrupt controller for the 16-peripheral interrupt subsystem.
- Latches interrupt requests from `intr_active` into a sticky pending register.
- Selects the highest-priority pending, enabled interrupt and presents it to the processor on `intr_valid`/`intr_to_serv`, holding it until `intr_service`.
- Per-peripheral priorities are programmed through the simple register port (`wr_rd`/`enable`/`addr`/`wdata` with `ready`/`error`/`rdata`).

Parameters:
- PERIPHERALS, 16, number of interrupt sources
- IDX_W, $clog2(PERIPHERALS) = 4, width of `addr` and `intr_to_serv`
- PRIO_W, $clog2(PERIPHERALS) = 4, width of each priority field, `wdata` and `rdata`

Ports:
- clk  in  1  single clock; all logic on posedge clk
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- wr_rd  in  1  1 = write, 0 = read
- enable  in  1  access request
- addr  in  IDX_W  peripheral index whose priority register is accessed
- wdata  in  PRIO_W  write priority value
- rdata  out  PRIO_W  read data
- ready  out  1  one-cycle access-complete pulse
- error  out  1  valid with `ready`; access rejected
- intr_active  in  PERIPHERALS  level interrupt requests
- intr_service  in  1  processor completion pulse
- intr_valid  out  1  interrupt presented to processor
- intr_to_serv  out  IDX_W  index of presented interrupt

Behaviour:
- Reset (rst = 0 at a posedge):
  - all priority registers = 0
  - pend = 0
  - FSM = IDLE
  - rdata = 0, ready = 0, error = 0, intr_valid = 0, intr_to_serv = 0
- Priority semantics:
  - priority 0 = masked
  - 1..15: larger value wins
  - ties go to the lowest index
- Register port:
  - An access is accepted at a posedge where enable = 1 and ready = 0.
  - At the next edge: ready = 1 for exactly one cycle; error is valid in that same cycle.
  - enable is ignored while ready = 1, so the maximum rate is one access per 2 cycles.
  - Read: rdata = prio[addr] captured at acceptance; error = 0. rdata holds until the next read.
  - Write: prio[addr] <= wdata at the accepting edge; error = 0.
    - Exception: if intr_valid = 1 and addr == intr_to_serv, the write is dropped and error = 1.
- Pending register:
  - Every posedge: pend <= (pend & ~clr) | intr_active.
  - clr is a one-hot of intr_to_serv, asserted only on the service-completion edge.
  - Set wins over clear: an intr_active bit high on the completion edge re-pends.
- Eligibility: elig[i] = pend[i] && prio[i] != 0.
  - A masked interrupt stays pending; it becomes eligible once its priority is written non-zero.
- FSM:
  - IDLE:
    - if elig != 0: latch winner into intr_to_serv, set intr_valid = 1, go to SERVE
    - else stay in IDLE
  - SERVE:
    - intr_valid = 1; intr_to_serv stable; no preemption even if a higher-priority request arrives
    - on a posedge with intr_service = 1: clear that pend bit, set intr_valid = 0, go to IDLE
- Latency: intr_active[i] sampled high at edge E → pend at E → intr_valid = 1 at E+1 (if IDLE).
- Minimum gap: intr_valid stays low for at least one cycle between consecutive grants.
- intr_service while in IDLE is ignored.
- Arbitration uses the priority values current at the decision edge; a write on the same edge is not seen until the next edge.
- Register accesses and scheduling proceed concurrently and independently, except for the write-reject rule above.
- Reset mid-SERVE: intr_valid drops at the reset edge and pending interrupts are lost.

Test Plan:
- Reset/defaults: rst = 0 for 2 cycles, then read addr 5 → ready pulse, rdata = 0, error = 0; intr_active = 16'h0020 → intr_valid stays 0 (masked).
- Basic grant: write prio[5] = 3, then intr_active = 16'h0020 for 1 cycle → intr_valid = 1 with intr_to_serv = 5 one edge after pend sets; hold 10 cycles, then pulse intr_service → intr_valid = 0 next cycle, pend[5] = 0.
- Priority/tie:
  - prio[2] = 7, prio[9] = 7, prio[12] = 4; intr_active = 16'h1204 → grants in order 2, 9, 12, each after an intr_service.
  - Separately, set prio[12] = 9 → 12 is granted first.
- No preemption/sticky: during SERVE of index 3 (prio 2), pulse intr_active[8] (prio 15) → intr_to_serv stays 3 until intr_service, then 8 is granted after a 1-cycle gap.
- Write reject: while serving index 4, write addr 4 wdata 1 → error = 1 with ready, prio[4] unchanged; write addr 6 at the same time → error = 0, updated.
- Set-wins and mid-op reset: hold intr_active[1] high across the intr_service edge → index 1 re-granted. Assert rst during SERVE → intr_valid = 0, pend = 0, priorities = 0.
